// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - multicycle RV32 sequencing FSM with unified memory handshake and watchdog
module multicycle_ctrl_fsm #(
    parameter int WAIT_MAX = 16
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic       zero_i,
    input  logic       alu_lsb_i,
    input  logic       mem_ready_i,
    output logic       mem_req_o,
    output logic       memwrite_o,
    output logic       iord_o,
    output logic       irwrite_o,
    output logic       pcwrite_o,
    output logic       pcsrc_o,
    output logic       regwrite_o,
    output logic [1:0] alusrc_a_o,
    output logic [1:0] alusrc_b_o,
    output logic [1:0] aluop_o,
    output logic [1:0] resultsrc_o,
    output logic       trap_o
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [4:0] WAIT_LAST = 5'(WAIT_MAX - 1);

    typedef enum logic [3:0] {
        RESET_S, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR,
        WB_ALU, WB_MEM, BRANCH, JAL, AUIPC, HALT
    } state_e;

    state_e     state_q, state_d;
    logic       trap_q, trap_d;
    logic [4:0] wait_q, wait_d;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= RESET_S;
            trap_q  <= 1'b0;
            wait_q  <= 5'd0;
        end else begin
            state_q <= state_d;
            trap_q  <= trap_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_req_o   = 1'b0;
        memwrite_o  = 1'b0;
        iord_o      = 1'b0;
        irwrite_o   = 1'b0;
        pcwrite_o   = 1'b0;
        pcsrc_o     = 1'b0;
        regwrite_o  = 1'b0;
        alusrc_a_o  = 2'b00;
        alusrc_b_o  = 2'b00;
        aluop_o     = 2'b00;
        resultsrc_o = 2'b00;
        case (state_q)
            RESET_S: state_d = FETCH;
            FETCH: begin
                mem_req_o  = 1'b1;
                alusrc_b_o = 2'b10;
                if (mem_ready_i) begin
                    irwrite_o = 1'b1;
                    pcwrite_o = 1'b1;
                    state_d   = DECODE;
                end
            end
            DECODE: begin
                alusrc_a_o = 2'b01;
                alusrc_b_o = 2'b01;
                case (opcode_i)
                    OP_R:              state_d = EXEC_R;
                    OP_I:              state_d = EXEC_I;
                    OP_LOAD, OP_STORE: state_d = MEM_ADDR;
                    OP_BR:             state_d = BRANCH;
                    OP_JAL:            state_d = JAL;
                    OP_AUIPC:          state_d = AUIPC;
                    default:           state_d = HALT;
                endcase
            end
            EXEC_R: begin
                alusrc_a_o = 2'b10;
                aluop_o    = 2'b10;
                state_d    = WB_ALU;
            end
            EXEC_I: begin
                alusrc_a_o = 2'b10;
                alusrc_b_o = 2'b01;
                aluop_o    = 2'b10;
                state_d    = WB_ALU;
            end
            WB_ALU: begin
                regwrite_o = 1'b1;
                state_d    = FETCH;
            end
            MEM_ADDR: begin
                alusrc_a_o = 2'b10;
                alusrc_b_o = 2'b01;
                state_d    = (opcode_i == OP_LOAD) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                mem_req_o = 1'b1;
                iord_o    = 1'b1;
                if (mem_ready_i) state_d = WB_MEM;
            end
            MEM_WR: begin
                mem_req_o  = 1'b1;
                memwrite_o = 1'b1;
                iord_o     = 1'b1;
                if (mem_ready_i) state_d = FETCH;
            end
            WB_MEM: begin
                regwrite_o  = 1'b1;
                resultsrc_o = 2'b01;
                state_d     = FETCH;
            end
            BRANCH: begin
                alusrc_a_o = 2'b10;
                aluop_o    = 2'b01;
                pcsrc_o    = 1'b1;
                // Only beq (zero) and blt (SLT result bit) are supported branch kinds.
                pcwrite_o  = (funct3_i == 3'b000) ? zero_i :
                             (funct3_i == 3'b100) ? alu_lsb_i : 1'b0;
                state_d    = FETCH;
            end
            JAL: begin
                regwrite_o  = 1'b1;
                resultsrc_o = 2'b10;
                alusrc_a_o  = 2'b01;
                alusrc_b_o  = 2'b10;
                pcwrite_o   = 1'b1;
                pcsrc_o     = 1'b1;
                state_d     = FETCH;
            end
            AUIPC: begin
                regwrite_o = 1'b1;
                state_d    = FETCH;
            end
            HALT:    state_d = HALT;
            default: state_d = HALT;
        endcase

        // An unanswered access that has exhausted its budget is abandoned, not retried.
        if ((WAIT_MAX != 0) && mem_req_o && !mem_ready_i && (wait_q == WAIT_LAST))
            state_d = HALT;
    end

    always_comb begin
        trap_d = trap_q | (state_d == HALT);
        if (state_d != state_q)
            wait_d = 5'd0;
        else if (mem_req_o && !mem_ready_i)
            wait_d = wait_q + 5'd1;
        else
            wait_d = wait_q;
    end

    assign trap_o = trap_q;

endmodule
